// File: rtl/sd4_mac_pkg.sv
// Shared widths, FSM encoding and beat-tag layout for the SD4 MAC job sequencer.
package sd4_mac_pkg;

    localparam int TAPS  = 9;
    localparam int IMG_W = TAPS * 8;
    localparam int WGT_W = TAPS * 4;
    localparam int EXP_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic valid;
        logic last_ch;
        logic last_pix;
    } beat_tag_t;

endpackage

// File: rtl/sd4_mac_sequencer_if.sv
// Window-beat input stream and tagged result output stream of the sequencer.
interface sd4_mac_sequencer_if #(
    parameter int RES_W = 16
) ();
    import sd4_mac_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [IMG_W-1:0] in_image;
    logic [WGT_W-1:0] in_weight;

    logic             out_valid;
    logic             out_ready;
    logic [RES_W-1:0] out_data;
    logic             out_last_ch;
    logic             out_last_pix;

    modport master (
        output in_valid, in_image, in_weight, out_ready,
        input  in_ready, out_valid, out_data, out_last_ch, out_last_pix
    );

    modport slave (
        input  in_valid, in_image, in_weight, out_ready,
        output in_ready, out_valid, out_data, out_last_ch, out_last_pix
    );

endinterface

// File: rtl/sd4_result_fifo.sv
// Synchronous result FIFO with occupancy count; DEPTH must be a power of two.
module sd4_result_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 18
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           head_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s, do_pop_s;

    // Pointer and count update; pointers wrap naturally at the power-of-two depth
    always_comb begin
        do_push_s = push && (count_q != CNT_W'(DEPTH));
        do_pop_s  = pop && (count_q != '0);
        wr_ptr_d  = do_push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d  = do_pop_s ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only observable while count is non-zero
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

    sd4_result_fifo_chk #(.DEPTH(DEPTH)) u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .count (count_q)
    );

endmodule

// File: rtl/sd4_result_fifo_chk.sv
// Protocol checker for the result FIFO: a push into a full FIFO without a pop is illegal.
module sd4_result_fifo_chk #(
    parameter int DEPTH = 4
) (
    input logic                     clk,
    input logic                     rst_n,
    input logic                     push,
    input logic                     pop,
    input logic [$clog2(DEPTH):0]   count
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // The credit limit upstream must keep the queue from ever overflowing
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (count == CNT_W'(DEPTH))))
        else $error("result fifo overflow");

endmodule

// File: rtl/sd4_mac_sequencer.sv
// Job-level controller for the SD4 MAC: issues window beats, tracks them through the
// fixed-latency MAC with a tag shift register, and queues results under a credit limit.
module sd4_mac_sequencer
    import sd4_mac_pkg::*;
#(
    parameter int PIPE_LAT   = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int RES_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_start,
    input  logic [15:0]        cfg_num_pix,
    input  logic [7:0]         cfg_num_ch,
    input  logic [EXP_W-1:0]   cfg_exp_bias,
    output logic               busy,
    output logic               done,
    sd4_mac_sequencer_if.slave bus,
    output logic [IMG_W-1:0]   mac_image,
    output logic [WGT_W-1:0]   mac_weight,
    output logic [EXP_W-1:0]   mac_exp_bias,
    input  logic [RES_W-1:0]   mac_result
);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int CRED_W = CNT_W + 1;
    localparam int ENT_W  = RES_W + 2;

    seq_state_e               state_q, state_d;
    logic [15:0]              num_pix_q, num_pix_d;
    logic [15:0]              pix_cnt_q, pix_cnt_d;
    logic [7:0]               num_ch_q, num_ch_d;
    logic [7:0]               ch_cnt_q, ch_cnt_d;
    logic [EXP_W-1:0]         exp_bias_q, exp_bias_d;
    beat_tag_t [PIPE_LAT-1:0] tag_sr_q, tag_sr_d;

    logic [CNT_W-1:0]  fifo_count_s;
    logic [CRED_W-1:0] inflight_s;
    logic [ENT_W-1:0]  push_data_s, head_s;
    logic              in_ready_s, fire_s, last_ch_s, last_pix_s;
    logic              push_s, pop_s, out_valid_s;

    // Credit: queued results plus beats still inside the MAC must fit in the FIFO
    always_comb begin
        inflight_s = '0;
        for (int i = 0; i < PIPE_LAT; i++) begin
            inflight_s = inflight_s + CRED_W'(tag_sr_q[i].valid);
        end
        in_ready_s = (state_q == ST_RUN) &&
                     ((CRED_W'(fifo_count_s) + inflight_s) < CRED_W'(FIFO_DEPTH));
        fire_s     = bus.in_valid && in_ready_s;
        last_ch_s  = (ch_cnt_q == (num_ch_q - 8'd1));
        last_pix_s = last_ch_s && (pix_cnt_q == (num_pix_q - 16'd1));
    end

    // Job FSM and configuration latch
    always_comb begin
        state_d    = state_q;
        num_pix_d  = num_pix_q;
        num_ch_d   = num_ch_q;
        exp_bias_d = exp_bias_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    num_pix_d  = cfg_num_pix;
                    num_ch_d   = (cfg_num_ch == 8'd0) ? 8'd1 : cfg_num_ch;
                    exp_bias_d = cfg_exp_bias;
                    state_d    = (cfg_num_pix == 16'd0) ? ST_DONE : ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (fire_s && last_pix_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (pop_s && head_s[0]) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Channel/pixel position of the next beat to be issued
    always_comb begin
        ch_cnt_d  = ch_cnt_q;
        pix_cnt_d = pix_cnt_q;
        if ((state_q == ST_IDLE) && cfg_start) begin
            ch_cnt_d  = 8'd0;
            pix_cnt_d = 16'd0;
        end else if (fire_s) begin
            if (last_ch_s) begin
                ch_cnt_d  = 8'd0;
                pix_cnt_d = pix_cnt_q + 16'd1;
            end else begin
                ch_cnt_d  = ch_cnt_q + 8'd1;
                pix_cnt_d = pix_cnt_q;
            end
        end else begin
            ch_cnt_d  = ch_cnt_q;
            pix_cnt_d = pix_cnt_q;
        end
    end

    // Tags travel alongside the MAC so each result lands with its own position flags
    always_comb begin
        tag_sr_d = '0;
        if (fire_s) begin
            tag_sr_d[0] = '{valid: 1'b1, last_ch: last_ch_s, last_pix: last_pix_s};
        end else begin
            tag_sr_d[0] = '0;
        end
        for (int i = 1; i < PIPE_LAT; i++) begin
            tag_sr_d[i] = tag_sr_q[i-1];
        end
    end

    // Sequencer state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            num_pix_q  <= 16'd0;
            pix_cnt_q  <= 16'd0;
            num_ch_q   <= 8'd0;
            ch_cnt_q   <= 8'd0;
            exp_bias_q <= '0;
            tag_sr_q   <= '0;
        end else begin
            state_q    <= state_d;
            num_pix_q  <= num_pix_d;
            pix_cnt_q  <= pix_cnt_d;
            num_ch_q   <= num_ch_d;
            ch_cnt_q   <= ch_cnt_d;
            exp_bias_q <= exp_bias_d;
            tag_sr_q   <= tag_sr_d;
        end
    end

    assign push_s      = tag_sr_q[PIPE_LAT-1].valid;
    assign push_data_s = {mac_result, tag_sr_q[PIPE_LAT-1].last_ch, tag_sr_q[PIPE_LAT-1].last_pix};
    assign out_valid_s = (fifo_count_s != '0);
    assign pop_s       = out_valid_s && bus.out_ready;

    sd4_result_fifo #(.DEPTH(FIFO_DEPTH), .W(ENT_W)) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head_data (head_s),
        .count     (fifo_count_s)
    );

    // Head fields are masked when empty so stale storage never reaches the outputs
    assign bus.in_ready     = in_ready_s;
    assign bus.out_valid    = out_valid_s;
    assign bus.out_data     = out_valid_s ? head_s[ENT_W-1:2] : '0;
    assign bus.out_last_ch  = out_valid_s && head_s[1];
    assign bus.out_last_pix = out_valid_s && head_s[0];

    assign busy         = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done         = (state_q == ST_DONE);
    assign mac_image    = bus.in_image;
    assign mac_weight   = bus.in_weight;
    assign mac_exp_bias = exp_bias_q;

endmodule

// File: tb/tb_sd4_mac_sequencer.sv
// Directed bench for sd4_mac_sequencer with a 3-stage MAC model and an issue-order scoreboard.
module tb_sd4_mac_sequencer;
    import sd4_mac_pkg::*;

    localparam int RES_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cfg_start = 1'b0;
    logic [15:0]      cfg_num_pix = 16'd0;
    logic [7:0]       cfg_num_ch = 8'd0;
    logic [EXP_W-1:0] cfg_exp_bias = 5'd0;
    logic             busy, done;
    logic [IMG_W-1:0] mac_image;
    logic [WGT_W-1:0] mac_weight;
    logic [EXP_W-1:0] mac_exp_bias;
    logic [RES_W-1:0] mac_result;
    logic [RES_W-1:0] mac_pipe [3];

    sd4_mac_sequencer_if #(.RES_W(RES_W)) bus ();

    sd4_mac_sequencer #(.PIPE_LAT(3), .FIFO_DEPTH(4), .RES_W(RES_W)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_num_pix(cfg_num_pix),
        .cfg_num_ch(cfg_num_ch), .cfg_exp_bias(cfg_exp_bias), .busy(busy), .done(done),
        .bus(bus), .mac_image(mac_image), .mac_weight(mac_weight),
        .mac_exp_bias(mac_exp_bias), .mac_result(mac_result)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mac_f(input logic [71:0] img, input logic [35:0] wgt);
        return {img[71:64], img[7:0]} ^ {4'h0, wgt[35:24]};
    endfunction
    function automatic logic [71:0] img_of(input logic [15:0] s);
        return {s[15:8], {7{s[7:0] ^ 8'h33}}, s[7:0]};
    endfunction
    function automatic logic [35:0] wgt_of(input logic [15:0] s);
        return {3{s[11:0]}};
    endfunction

    // MAC model: three register stages between mac_image/mac_weight and mac_result
    always @(posedge clk) begin
        mac_pipe[0] <= mac_f(mac_image, mac_weight);
        mac_pipe[1] <= mac_pipe[0];
        mac_pipe[2] <= mac_pipe[1];
    end
    assign mac_result = mac_pipe[2];

    int n_total = 0, n_pass = 0, n_fail = 0;
    int cyc = 0, start_cyc = 0;
    int job_pix = 0, job_ch = 1, tb_ch = 0, tb_pix = 0;
    int fires = 0, pops = 0, done_cnt = 0, done_cyc = -1, lastpix_pop_cyc = -1;
    int first_ov_cyc = -1, max_out = 0;
    int fire_cyc[$];
    logic [17:0] exp_q[$];
    logic [15:0] seq = 16'h1234;
    logic        stall_prev = 1'b0;
    logic [18:0] stall_snap = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, drive next inputs, update scoreboard
    task automatic cycle(input logic v, input logic r);
        logic        rdy, ov, lc, lp;
        logic [18:0] head;
        logic [17:0] e;
        @(negedge clk);
        cyc++;
        rdy  = bus.in_ready;
        ov   = bus.out_valid;
        head = {ov, bus.out_data, bus.out_last_ch, bus.out_last_pix};
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (ov && first_ov_cyc < 0) first_ov_cyc = cyc;
        if (stall_prev) check("stall_hold", 32'(head), 32'(stall_snap));
        bus.in_valid  = v;
        bus.in_image  = img_of(seq);
        bus.in_weight = wgt_of(seq);
        bus.out_ready = r;
        if (v && rdy) begin
            lc = (tb_ch == job_ch - 1);
            lp = lc && (tb_pix == job_pix - 1);
            exp_q.push_back({mac_f(img_of(seq), wgt_of(seq)), lc, lp});
            fire_cyc.push_back(cyc);
            fires++;
            seq = seq + 16'h0137;
            if (lc) begin tb_ch = 0; tb_pix++; end
            else tb_ch++;
        end
        if (ov && r) begin
            pops++;
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else e = 18'h3FFFF;
            check("result", 32'(head[17:0]), 32'(e));
            if (e[0]) lastpix_pop_cyc = cyc;
        end
        if (exp_q.size() > max_out) max_out = exp_q.size();
        stall_prev = ov && !r;
        stall_snap = head;
    endtask

    task automatic start_job(input int pix, input int ch, input logic [4:0] bias);
        @(negedge clk);
        cfg_num_pix = 16'(pix); cfg_num_ch = 8'(ch); cfg_exp_bias = bias; cfg_start = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        job_pix = pix; job_ch = (ch == 0) ? 1 : ch; tb_ch = 0; tb_pix = 0;
        fires = 0; pops = 0; done_cnt = 0; done_cyc = -1; lastpix_pop_cyc = -1;
        first_ov_cyc = -1; max_out = 0; stall_prev = 1'b0; fire_cyc.delete(); exp_q.delete();
        start_cyc = cyc;
        @(posedge clk);
        #1 cfg_start = 1'b0;
    endtask

    task automatic run_job(input int mode, input int budget, input string tag);
        for (int k = 0; k < budget && done_cnt == 0; k++) begin
            if (mode == 0) cycle(1'b1, 1'b1);
            else cycle($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1);
        end
        check({tag, "_finished"}, 32'(done_cnt), 32'd1);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_image = '0; bus.in_weight = '0; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_last_flags", 32'({bus.out_last_ch, bus.out_last_pix}), 32'd0);
        check("rst_exp_bias", 32'(mac_exp_bias), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // 1: 2 pixels x 3 channels, consumer always ready
        start_job(2, 3, 5'h0B);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_exp_bias", 32'(mac_exp_bias), 32'h0B);
        run_job(0, 100, "t1");
        check("t1_fires", 32'(fires), 32'd6);
        check("t1_pops", 32'(pops), 32'd6);
        check("t1_latency", 32'(first_ov_cyc - fire_cyc[0]), 32'd4);
        check("t1_credit_gap", 32'(fire_cyc[4] - fire_cyc[0]), 32'd5);
        check("t1_done_after_pop", 32'(done_cyc - lastpix_pop_cyc), 32'd1);
        cycle(1'b0, 1'b1);
        check("t1_done_pulse", 32'(done_cnt), 32'd1);
        check("t1_idle_busy", 32'(busy), 32'd0);

        // 2: consumer stalled, credit limits issue to FIFO_DEPTH beats
        start_job(1, 8, 5'h02);
        repeat (12) cycle(1'b1, 1'b0);
        check("t2_fires_stalled", 32'(fires), 32'd4);
        check("t2_in_ready_low", 32'(bus.in_ready), 32'd0);
        check("t2_out_valid", 32'(bus.out_valid), 32'd1);
        run_job(0, 100, "t2");
        check("t2_fires", 32'(fires), 32'd8);
        check("t2_pops", 32'(pops), 32'd8);

        // 3: random valid/ready traffic, 20 pixels x 5 channels
        start_job(20, 5, 5'h11);
        run_job(1, 3000, "t3");
        check("t3_fires", 32'(fires), 32'd100);
        check("t3_pops", 32'(pops), 32'd100);
        check("t3_outstanding_le4", 32'(max_out <= 4), 32'd1);

        // 4: empty job goes straight to DONE
        start_job(0, 3, 5'h07);
        check("t4_done_now", 32'(done), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (3) cycle(1'b1, 1'b1);
        check("t4_done_cyc", 32'(done_cyc - start_cyc), 32'd1);
        check("t4_done_pulse", 32'(done_cnt), 32'd1);
        check("t4_no_fires", 32'(fires), 32'd0);

        // 5: reset with three beats inside the MAC
        start_job(4, 2, 5'h0A);
        repeat (3) cycle(1'b1, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("t5_pre_busy", 32'(busy), 32'd1);
        check("t5_pre_in_ready", 32'(bus.in_ready), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("t5_rst_exp_bias", 32'(mac_exp_bias), 32'd0);
        check("t5_rst_out", 32'({bus.out_valid, bus.out_data, bus.out_last_ch, bus.out_last_pix, done}), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        start_job(1, 2, 5'h1C);
        run_job(0, 100, "t5");
        check("t5_pops", 32'(pops), 32'd2);
        repeat (6) cycle(1'b0, 1'b1);
        check("t5_no_leftover", 32'(pops), 32'd2);
        check("t5_out_valid", 32'(bus.out_valid), 32'd0);

        // 6: cfg_start during RUN ignored; num_ch=0 acts as one channel
        start_job(3, 0, 5'h15);
        cycle(1'b1, 1'b1);
        cfg_start = 1'b1; cfg_num_pix = 16'd7; cfg_num_ch = 8'd4; cfg_exp_bias = 5'h03;
        cycle(1'b1, 1'b1);
        cfg_start = 1'b0;
        check("t6_exp_bias_held", 32'(mac_exp_bias), 32'h15);
        run_job(0, 100, "t6");
        check("t6_fires", 32'(fires), 32'd3);
        check("t6_pops", 32'(pops), 32'd3);
        cycle(1'b0, 1'b1);
        check("t6_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
